digit_entry_shaper: RTL and testbench
=====================================

Name: digit_entry_shaper

Overview:
- Front-end stage for the 4-bit digit register. Takes a raw pushbutton and 4 raw slide switches and produces a clean 4-bit digit plus a single-cycle load strobe.
- Digit_Out and Load_Out connect directly to the register's data input and Load input.
- Guarantees exactly one Load pulse per physical press: synchronizes, debounces, captures the switches at the press, then blocks until release.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive cycles the synchronized button must hold a new level before it is accepted. Legal range 1 to 2^20-1.
- CNT_W, 20, width of the debounce counter. Must hold DEBOUNCE_CYCLES-1.

Ports:
- Clk  in  1  system clock; all flops on posedge.
- Rst  in  1  asynchronous, active-low reset.
- Btn_In  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to Clk.
- Sw_In  in  4  raw slide switches, asynchronous to Clk.
- Digit_Out  out  4  captured digit, held until the next accepted press.
- Load_Out  out  1  one-cycle strobe; Digit_Out is valid in the same cycle.
- Err_Out  out  1  one-cycle range-error strobe (feature-dependent, see below).

Behaviour:
- Reset:
  - Rst=0 asynchronously clears every flop.
  - Digit_Out=4'b0000, Load_Out=0, Err_Out=0.
  - Synchronizer flops=1 (released), Sw synchronizers=0, stable button=1, counter=0, state=IDLE.
  - Reset mid-press: the press is discarded. After reset deasserts, a still-held button must first debounce to pressed and is then accepted as a new press.
- Synchronization:
  - 2-FF synchronizer on Btn_In (btn_s) and on each Sw_In bit (sw_s).
  - Only btn_s and sw_s are used downstream.
- Debounce:
  - Register btn_stable, reset value 1.
  - If btn_s == btn_stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: btn_stable <= btn_s and counter <= 0.
  - Else: counter <= counter+1.
  - Any bounce back to btn_stable restarts the count.
- FSM states: IDLE, WAIT_RELEASE.
  - IDLE, btn_stable==0: capture sw_s, assert the strobe (Load_Out or Err_Out) next cycle, go to WAIT_RELEASE.
  - IDLE, otherwise: stay in IDLE.
  - WAIT_RELEASE, btn_stable==1: go to IDLE.
  - WAIT_RELEASE, otherwise: stay; no strobes.
- Outputs:
  - Load_Out and Err_Out are registered and high for exactly one cycle per accepted press.
  - Digit_Out is updated on the same edge that sets Load_Out, and is unchanged otherwise.
  - Err_Out never leaves Digit_Out changed.
- Latency: the raw edge is first sampled at clock edge k.
  - btn_s changes at edge k+1.
  - btn_stable changes at edge k+1+DEBOUNCE_CYCLES.
  - Load_Out is high after edge k+2+DEBOUNCE_CYCLES and low after the following edge.
- Switches:
  - Value is sampled at the IDLE->WAIT_RELEASE transition.
  - Switch changes while held or released have no effect until the next press.
- Holding the button indefinitely produces exactly one strobe.
- A release shorter than DEBOUNCE_CYCLES is ignored; no second strobe.

Optional Feature:
- Macro: DIGIT_RANGE_CHECK_EN.
- Defined: captured values 10..15 do not update Digit_Out and do not pulse Load_Out. Err_Out pulses for one cycle instead, with the same timing as Load_Out would have. Values 0..9 behave normally.
- Undefined: all 16 values load normally, and Err_Out is tied to constant 0.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: Rst=0 mid-operation -> all outputs 0 immediately, without a clock edge; after release with Btn_In=1 steady, no strobes for 50 cycles.
- Clean press: Sw_In=4'h7, Btn_In 1->0 held 20 cycles -> exactly one Load_Out pulse 6 edges after first sample, Digit_Out=4'h7, Load_Out low for the remaining held cycles.
- Bounce: Btn_In toggles 0/1 every 2 cycles for 12 cycles, then steady 0 -> no pulse during toggling, one pulse 6 edges after steady 0 is first sampled.
- Switch change while held: press with Sw_In=4'h3, change to 4'hC before release -> Digit_Out stays 4'h3; the next press captures 4'hC.
- Short release glitch: held, Btn_In=1 for 2 cycles, then 0 again -> no second Load_Out.
- Range (macro defined): Sw_In=4'hB press -> Err_Out single pulse, Load_Out stays 0, Digit_Out unchanged. Same press with macro undefined -> Load_Out pulse, Digit_Out=4'hB, Err_Out=0.

Source files
------------

// File: rtl/digit_entry_shaper.sv
// Pushbutton/switch front end: synchronize, debounce, capture switches once per press, strobe load.
// Define DIGIT_RANGE_CHECK_EN to turn captures of 10..15 into an Err_Out strobe instead of a load.
module digit_entry_shaper #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Btn_In,
    input  logic [3:0] Sw_In,
    output logic [3:0] Digit_Out,
    output logic       Load_Out,
    output logic       Err_Out
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StWaitRelease
    } state_e;

    logic             btn_meta_q;
    logic             btn_s_q;
    logic [3:0]       sw_meta_q;
    logic [3:0]       sw_s_q;
    logic             btn_stable_q;
    logic             btn_stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    state_e           state_q;
    state_e           state_d;
    logic [3:0]       digit_q;
    logic [3:0]       digit_d;
    logic             load_q;
    logic             load_d;
`ifdef DIGIT_RANGE_CHECK_EN
    logic             err_q;
    logic             err_d;
`endif

    // Button idles high (released), so its synchronizer resets to 1.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            btn_meta_q <= 1'b1;
            btn_s_q    <= 1'b1;
            sw_meta_q  <= 4'h0;
            sw_s_q     <= 4'h0;
        end else begin
            btn_meta_q <= Btn_In;
            btn_s_q    <= btn_meta_q;
            sw_meta_q  <= Sw_In;
            sw_s_q     <= sw_meta_q;
        end
    end

    // A new level is accepted only after it holds for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        btn_stable_d = btn_stable_q;
        cnt_d        = cnt_q;
        if (btn_s_q == btn_stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            btn_stable_d = btn_s_q;
            cnt_d        = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            btn_stable_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            btn_stable_q <= btn_stable_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        load_d  = 1'b0;
`ifdef DIGIT_RANGE_CHECK_EN
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (!btn_stable_q) begin
                    state_d = StWaitRelease;
`ifdef DIGIT_RANGE_CHECK_EN
                    if (sw_s_q > 4'd9) begin
                        err_d = 1'b1;
                    end else begin
                        load_d  = 1'b1;
                        digit_d = sw_s_q;
                    end
`else
                    load_d  = 1'b1;
                    digit_d = sw_s_q;
`endif
                end
            end
            StWaitRelease: begin
                if (btn_stable_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StIdle;
            digit_q <= 4'h0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            load_q  <= load_d;
        end
    end

`ifdef DIGIT_RANGE_CHECK_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Err_Out = err_q;
`else
    assign Err_Out = 1'b0;
`endif

    assign Digit_Out = digit_q;
    assign Load_Out  = load_q;

endmodule

// File: tb/tb_digit_entry_shaper.sv
// Bench for digit_entry_shaper: press table, hand-written corner sequences, and random
// button/switch activity checked cycle by cycle against a sample-window reference model.
module tb_digit_entry_shaper;

    localparam int Deb = 4;
`ifdef DIGIT_RANGE_CHECK_EN
    localparam bit RangeEn = 1'b1;
`else
    localparam bit RangeEn = 1'b0;
`endif

    logic       Clk    = 1'b0;
    logic       Rst    = 1'b0;
    logic       Btn_In = 1'b1;
    logic [3:0] Sw_In  = 4'h0;
    logic [3:0] Digit_Out;
    logic       Load_Out;
    logic       Err_Out;

    always #5 Clk = ~Clk;

    digit_entry_shaper #(
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (20)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Btn_In   (Btn_In),
        .Sw_In    (Sw_In),
        .Digit_Out(Digit_Out),
        .Load_Out (Load_Out),
        .Err_Out  (Err_Out)
    );

    typedef struct {
        logic [3:0] sw;
        int         hold;
        int         rel;
        int         exp_loads;
        int         exp_errs;
        logic [3:0] exp_digit;
    } vec_t;

    vec_t vecs[5];

    int checks   = 0;
    int failures = 0;
    int tick_idx = 0;
    int mark     = 0;
    int n_load   = 0;
    int n_err    = 0;
    int strobe_at = -1;

    // Reference model state: input delay lines, accepted button level, recent samples.
    logic       m_meta, m_bs, m_stable, m_fell, m_load, m_err;
    logic [3:0] m_swm, m_sws, m_digit;
    logic       win[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tick %0d)", name, act, exp, tick_idx);
        end
    endtask

    task automatic model_reset();
        m_meta   = 1'b1;
        m_bs     = 1'b1;
        m_swm    = 4'h0;
        m_sws    = 4'h0;
        m_stable = 1'b1;
        m_fell   = 1'b0;
        m_load   = 1'b0;
        m_err    = 1'b0;
        m_digit  = 4'h0;
        win.delete();
    endtask

    // A new button level is accepted once the last Deb synchronized samples all differ
    // from the accepted level; every accepted press strobes one cycle later.
    task automatic model_step(input logic btn, input logic [3:0] sw);
        logic       bs_pre;
        logic [3:0] sws_pre;
        bit         all_diff;
        bs_pre  = m_bs;
        sws_pre = m_sws;
        m_load  = 1'b0;
        m_err   = 1'b0;
        if (m_fell) begin
            if (RangeEn && sws_pre > 4'd9) begin
                m_err = 1'b1;
            end else begin
                m_load  = 1'b1;
                m_digit = sws_pre;
            end
        end
        m_fell = 1'b0;
        win.push_back(bs_pre);
        if (win.size() > Deb) void'(win.pop_front());
        all_diff = (win.size() == Deb);
        foreach (win[i]) if (win[i] == m_stable) all_diff = 1'b0;
        if (all_diff) begin
            m_stable = ~m_stable;
            m_fell   = ~m_stable;
            win.delete();
        end
        m_bs   = m_meta;
        m_meta = btn;
        m_sws  = m_swm;
        m_swm  = sw;
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, compare.
    task automatic tick(input logic btn, input logic [3:0] sw);
        Btn_In = btn;
        Sw_In  = sw;
        if (Rst) model_step(btn, sw);
        else model_reset();
        @(negedge Clk);
        check("load", {31'b0, Load_Out}, {31'b0, m_load});
        check("err", {31'b0, Err_Out}, {31'b0, m_err});
        check("digit", {28'b0, Digit_Out}, {28'b0, m_digit});
        if (Load_Out || Err_Out) begin
            if (strobe_at < 0) strobe_at = tick_idx - mark;
        end
        if (Load_Out) n_load++;
        if (Err_Out) n_err++;
        tick_idx++;
    endtask

    task automatic begin_seq();
        mark      = tick_idx;
        n_load    = 0;
        n_err     = 0;
        strobe_at = -1;
    endtask

    initial begin
        logic       lvl;
        int         run;
        logic [3:0] sw_r;

        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        check("reset_digit", {28'b0, Digit_Out}, 32'h0);
        check("reset_load", {31'b0, Load_Out}, 32'h0);
        check("reset_err", {31'b0, Err_Out}, 32'h0);
        Rst = 1'b1;
        repeat (10) tick(1'b1, 4'h0);

        vecs[0] = '{4'h7, 20, 20, 1, 0, 4'h7};
        vecs[1] = '{4'hB, 20, 20, RangeEn ? 0 : 1, RangeEn ? 1 : 0, RangeEn ? 4'h7 : 4'hB};
        vecs[2] = '{4'h0, 20, 20, 1, 0, 4'h0};
        vecs[3] = '{4'hF, 20, 20, RangeEn ? 0 : 1, RangeEn ? 1 : 0, RangeEn ? 4'h0 : 4'hF};
        vecs[4] = '{4'h9, 20, 20, 1, 0, 4'h9};

        for (int v = 0; v < 5; v++) begin
            begin_seq();
            for (int i = 0; i < vecs[v].hold; i++) tick(1'b0, vecs[v].sw);
            for (int i = 0; i < vecs[v].rel; i++) tick(1'b1, vecs[v].sw);
            check($sformatf("vec%0d_loads", v), n_load, vecs[v].exp_loads);
            check($sformatf("vec%0d_errs", v), n_err, vecs[v].exp_errs);
            check($sformatf("vec%0d_strobe_at", v), strobe_at, 6);
            check($sformatf("vec%0d_digit", v), {28'b0, Digit_Out}, {28'b0, vecs[v].exp_digit});
        end

        // Bounce every 2 cycles never satisfies the debounce window.
        begin_seq();
        for (int i = 0; i < 12; i++) tick(((i / 2) % 2) == 1, 4'h6);
        check("bounce_no_pulse", n_load + n_err, 0);
        begin_seq();
        repeat (15) tick(1'b0, 4'h6);
        check("bounce_loads", n_load, 1);
        check("bounce_strobe_at", strobe_at, 6);
        check("bounce_digit", {28'b0, Digit_Out}, 32'h6);
        repeat (15) tick(1'b1, 4'h6);

        begin_seq();
        repeat (10) tick(1'b0, 4'h3);
        repeat (10) tick(1'b0, 4'hC);
        repeat (15) tick(1'b1, 4'hC);
        check("swchg_loads", n_load, 1);
        check("swchg_digit", {28'b0, Digit_Out}, 32'h3);
        begin_seq();
        repeat (15) tick(1'b0, 4'hC);
        repeat (15) tick(1'b1, 4'hC);
        check("swnext_strobes", n_load + n_err, 1);
        check("swnext_digit", {28'b0, Digit_Out}, RangeEn ? 32'h3 : 32'hC);

        begin_seq();
        repeat (15) tick(1'b0, 4'h2);
        repeat (2) tick(1'b1, 4'h2);
        repeat (15) tick(1'b0, 4'h2);
        repeat (15) tick(1'b1, 4'h2);
        check("glitch_loads", n_load, 1);
        check("glitch_digit", {28'b0, Digit_Out}, 32'h2);

        // Reset lands in the cycle Load_Out is high; the held press is re-debounced afterwards.
        begin_seq();
        repeat (7) tick(1'b0, 4'h5);
        check("prereset_load", {31'b0, Load_Out}, 32'h1);
        #2 Rst = 1'b0;
        #1;
        check("async_reset_digit", {28'b0, Digit_Out}, 32'h0);
        check("async_reset_load", {31'b0, Load_Out}, 32'h0);
        check("async_reset_err", {31'b0, Err_Out}, 32'h0);
        @(negedge Clk);
        model_reset();
        repeat (3) tick(1'b0, 4'h5);
        Rst = 1'b1;
        begin_seq();
        repeat (12) tick(1'b0, 4'h5);
        check("held_after_reset_loads", n_load, 1);
        check("held_after_reset_at", strobe_at, 6);
        check("held_after_reset_digit", {28'b0, Digit_Out}, 32'h5);
        repeat (20) tick(1'b1, 4'h5);

        Rst = 1'b0;
        repeat (3) tick(1'b1, 4'h9);
        Rst = 1'b1;
        begin_seq();
        repeat (50) tick(1'b1, 4'($urandom));
        check("idle_after_reset_strobes", n_load + n_err, 0);
        check("idle_after_reset_digit", {28'b0, Digit_Out}, 32'h0);

        lvl  = 1'b1;
        sw_r = 4'($urandom);
        for (int r = 0; r < 600; r++) begin
            lvl = ~lvl;
            run = $urandom_range(1, 9);
            for (int i = 0; i < run; i++) begin
                if ($urandom_range(0, 7) == 0) sw_r = 4'($urandom);
                tick(lvl, sw_r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
